// File: rtl/rgb_line_doubler_pkg.sv
// Shared constants, pixel type and write-side state encoding for the
// 2x line-doubling camera-to-HDMI feeder.
package rgb_pkg;

    localparam int SRC_W = 320;
    localparam int SRC_H = 240;
    localparam int DW    = 24;

    typedef logic [DW-1:0] pixel_t;

    typedef enum logic [2:0] {
        FLUSH    = 3'd0,
        WAIT_SOF = 3'd1,
        FILL     = 3'd2,
        STALL    = 3'd3,
        DONE     = 3'd4
    } wr_state_t;

endpackage

// File: rtl/rgb_line_doubler_line_buf_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output (read data appears the cycle after rd_en).
module line_buf_ram #(
    parameter int AW = 10,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    // No reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rgb_line_doubler.sv
// Ping-pong line buffer that upscales a 320x240 stream 2x: each pixel is
// read twice per output line and each source line feeds two output lines.
module rgb_line_doubler
    import rgb_pkg::*;
#(
    parameter int SRC_W = rgb_pkg::SRC_W,
    parameter int SRC_H = rgb_pkg::SRC_H,
    parameter int DW    = rgb_pkg::DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    input  logic          vsync_n,
    input  logic          mem_read,
    output logic [DW-1:0] mem_data,
    output logic          underrun,
    output logic          frame_err
);

    localparam int IW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int CW = IW + 1;
    localparam int AW = IW + 1;
    localparam int LW = $clog2(SRC_H + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(SRC_W - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(2 * SRC_W - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(SRC_H - 1);

    wr_state_t     state_q, state_d;
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [LW-1:0] wr_line_q, wr_line_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rep_q, rep_d;
    logic          line_black_q, line_black_d;
    logic          underrun_q, underrun_d;
    logic          frame_err_q, frame_err_d;
    logic          out_en_q, out_en_d;

    logic          accept;
    logic          restart;
    logic          black_now;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    assign s_ready = (state_q != STALL);

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        wr_idx_d     = wr_idx_q;
        wr_line_d    = wr_line_q;
        rd_cnt_d     = rd_cnt_q;
        rep_d        = rep_q;
        line_black_d = line_black_q;
        underrun_d   = underrun_q;
        frame_err_d  = 1'b0;
        out_en_d     = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        wr_addr      = {wr_sel_q, wr_idx_q};
        rd_addr      = {rd_sel_q, rd_cnt_q[CW-1:1]};

        accept    = s_valid & s_ready;
        restart   = accept & s_sof & (state_q inside {FILL, STALL, DONE})
                    & ((wr_idx_q != '0) | (wr_line_q != '0));
        // The first read of a line decides black-ness from the live flag.
        black_now = (rd_cnt_q == '0) ? ~full_q[rd_sel_q] : line_black_q;

        if (!vsync_n) begin
            state_d      = FLUSH;
            full_d       = 2'b00;
            wr_sel_d     = 1'b0;
            rd_sel_d     = 1'b0;
            wr_idx_d     = '0;
            wr_line_d    = '0;
            rd_cnt_d     = '0;
            rep_d        = 1'b0;
            line_black_d = 1'b0;
        end else if (restart) begin
            frame_err_d  = 1'b1;
            full_d       = 2'b00;
            wr_sel_d     = 1'b0;
            rd_sel_d     = 1'b0;
            rd_cnt_d     = '0;
            rep_d        = 1'b0;
            line_black_d = 1'b0;
            wr_en        = 1'b1;
            wr_addr      = '0;
            wr_idx_d     = IW'(1);
            wr_line_d    = '0;
            state_d      = FILL;
        end else begin
            if (mem_read) begin
                rd_en    = 1'b1;
                out_en_d = ~black_now;
                if (rd_cnt_q == '0) begin
                    line_black_d = ~full_q[rd_sel_q];
                    if (!full_q[rd_sel_q]) begin
                        underrun_d = 1'b1;
                    end
                end
                if (rd_cnt_q == CNT_LAST) begin
                    rd_cnt_d = '0;
                    // Black lines retry the same buffer on the next output line.
                    if (!black_now) begin
                        rep_d = ~rep_q;
                        if (rep_q) begin
                            full_d[rd_sel_q] = 1'b0;
                            rd_sel_d         = ~rd_sel_q;
                        end
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end

            case (state_q)
                FLUSH: state_d = WAIT_SOF;
                WAIT_SOF, FILL: begin
                    if (accept && (state_q == FILL || s_sof)) begin
                        wr_en = 1'b1;
                        if (wr_idx_q == IDX_LAST) begin
                            full_d[wr_sel_q] = 1'b1;
                            wr_sel_d         = ~wr_sel_q;
                            wr_idx_d         = '0;
                            wr_line_d        = wr_line_q + LW'(1);
                            if (wr_line_q == LINE_LAST) begin
                                state_d = DONE;
                            end else if (full_q[~wr_sel_q]) begin
                                state_d = STALL;
                            end else begin
                                state_d = FILL;
                            end
                        end else begin
                            wr_idx_d = wr_idx_q + IW'(1);
                            state_d  = FILL;
                        end
                    end
                end
                STALL: begin
                    if (!full_q[wr_sel_q]) begin
                        state_d = FILL;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= WAIT_SOF;
            full_q       <= 2'b00;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            wr_idx_q     <= '0;
            wr_line_q    <= '0;
            rd_cnt_q     <= '0;
            rep_q        <= 1'b0;
            line_black_q <= 1'b0;
            underrun_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            out_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_idx_q     <= wr_idx_d;
            wr_line_q    <= wr_line_d;
            rd_cnt_q     <= rd_cnt_d;
            rep_q        <= rep_d;
            line_black_q <= line_black_d;
            underrun_q   <= underrun_d;
            frame_err_q  <= frame_err_d;
            out_en_q     <= out_en_d;
        end
    end

    line_buf_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign mem_data  = out_en_q ? rd_data : '0;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rgb_line_doubler.sv
// Directed-sequence bench with random pixel data, checked against a queue
// model of source lines (each queued line is expected on two output lines).
module tb_rgb_line_doubler;

    localparam int W   = rgb_pkg::SRC_W;
    localparam int H   = rgb_pkg::SRC_H;
    localparam int RL  = 2 * W;
    localparam int TMO = 4000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        vsync_n = 1'b1;
    logic        mem_read = 1'b0;
    logic [23:0] mem_data;
    logic        underrun;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;

    // Reference model: completed source lines waiting to be shown, the
    // partially received line, and frame bookkeeping.
    logic [23:0] mq[$];
    logic [23:0] part[$];
    int          lines_done = 0;
    bit          in_frame = 1'b0;
    bit          m_rep = 1'b0;
    bit          m_under = 1'b0;
    bit          exp_ferr = 1'b0;
    logic [23:0] got [RL];

    always #5 clk = ~clk;

    rgb_line_doubler dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .vsync_n   (vsync_n),
        .mem_read  (mem_read),
        .mem_data  (mem_data),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        mq.delete();
        part.delete();
        m_rep      = 1'b0;
        in_frame   = 1'b0;
        lines_done = 0;
    endtask

    task automatic model_accept(input logic [23:0] d, input bit sof);
        if (sof && in_frame && (part.size() != 0 || lines_done != 0)) begin
            mq.delete();
            part.delete();
            m_rep      = 1'b0;
            lines_done = 0;
            exp_ferr   = 1'b1;
        end
        if (sof && !in_frame) begin
            lines_done = 0;
        end
        if (sof) in_frame = 1'b1;
        if (in_frame && lines_done < H) begin
            part.push_back(d);
            if (part.size() == W) begin
                foreach (part[k]) mq.push_back(part[k]);
                part.delete();
                lines_done++;
            end
        end
    endtask

    task automatic send_pixel(input logic [23:0] d, input bit sof);
        int waitc = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && waitc < TMO) begin
            step();
            waitc++;
        end
        if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
        stall_cnt += waitc;
        step();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        model_accept(d, sof);
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        exp_ferr = 1'b0;
    endtask

    task automatic send_line(input int n, input bit sof_first, input bit ramp);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            d = ramp ? 24'(i) : 24'($urandom);
            send_pixel(d, sof_first && (i == 0));
        end
    endtask

    task automatic read_line(input string tag);
        bit          have;
        int          bad_i;
        logic [23:0] e;
        have = (mq.size() >= W);
        for (int i = 0; i < RL; i++) begin
            mem_read = 1'b1;
            step();
            got[i] = mem_data;
        end
        mem_read = 1'b0;
        step();
        check({tag, "_idle"}, 32'(mem_data), 32'd0);
        bad_i = RL - 1;
        for (int i = 0; i < RL; i++) begin
            e = have ? mq[i / 2] : 24'h0;
            if (got[i] !== e) begin
                bad_i = i;
                break;
            end
        end
        e = have ? mq[bad_i / 2] : 24'h0;
        check(tag, 32'(got[bad_i]), 32'(e));
        if (!have) begin
            m_under = 1'b1;
        end else if (m_rep) begin
            repeat (W) void'(mq.pop_front());
            m_rep = 1'b0;
        end else begin
            m_rep = 1'b1;
        end
        check({tag, "_underrun"}, 32'(underrun), 32'(m_under));
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) step();
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_full", 32'(dut.full_q), 32'd0);
        rstn = 1'b1;
        step();

        // Basic fill with a ramp line
        stall_cnt = 0;
        send_line(W, 1'b1, 1'b1);
        check("fill_stall", 32'(stall_cnt), 32'd0);
        check("fill_full", 32'(dut.full_q), 32'd1);
        check("fill_wr_sel", 32'(dut.wr_sel_q), 32'd1);
        check("fill_ready", 32'(s_ready), 32'd1);

        // Doubling: the same source line on two output lines
        read_line("dbl_a");
        read_line("dbl_b");
        check("dbl_full", 32'(dut.full_q), 32'd0);
        check("dbl_rd_sel", 32'(dut.rd_sel_q), 32'd1);

        // Back-pressure: both buffers full, no reads
        stall_cnt = 0;
        send_line(W, 1'b0, 1'b0);
        send_line(W, 1'b0, 1'b0);
        check("bp_stall", 32'(stall_cnt), 32'd0);
        check("bp_ready", 32'(s_ready), 32'd0);
        check("bp_full", 32'(dut.full_q), 32'd3);
        read_line("bp_l1_a");
        check("bp_ready_half", 32'(s_ready), 32'd0);
        read_line("bp_l1_b");
        n = 0;
        while (!s_ready && n < 2) begin
            step();
            n++;
        end
        check("bp_release", 32'(s_ready), 32'd1);
        read_line("bp_l2_a");
        read_line("bp_l2_b");
        check("bp_empty", 32'(dut.full_q), 32'd0);

        // Underrun: read with nothing buffered, then recover
        read_line("ur_black");
        send_line(W, 1'b0, 1'b0);
        read_line("ur_a");
        read_line("ur_b");

        // Random lines
        for (int r = 0; r < 3; r++) begin
            send_line(W, 1'b0, 1'b0);
            read_line("rnd_a");
            read_line("rnd_b");
        end

        // Vsync flush mid-line
        send_line(150, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            mem_read = 1'b1;
            step();
            got[i] = mem_data;
        end
        mem_read = 1'b0;
        check("vs_black_rd", 32'(got[199]), 32'd0);
        check("vs_rd_cnt_pre", 32'(dut.rd_cnt_q), 32'd200);
        vsync_n = 1'b0;
        step();
        step();
        model_flush();
        check("vs_full", 32'(dut.full_q), 32'd0);
        check("vs_rd_cnt", 32'(dut.rd_cnt_q), 32'd0);
        check("vs_ready", 32'(s_ready), 32'd1);
        vsync_n = 1'b1;
        step();
        stall_cnt = 0;
        send_line(5, 1'b0, 1'b0);
        check("vs_drop_ready", 32'(stall_cnt), 32'd0);
        check("vs_drop_full", 32'(dut.full_q), 32'd0);
        send_line(W, 1'b1, 1'b0);
        check("vs_new_full", 32'(dut.full_q), 32'd1);
        read_line("vs_a");
        read_line("vs_b");

        // Mid-frame SOF with a full buffer pending
        send_line(W, 1'b0, 1'b0);
        send_line(100, 1'b0, 1'b0);
        send_pixel(24'($urandom), 1'b1);
        check("mid_full_clr", 32'(dut.full_q), 32'd0);
        step();
        check("mid_ferr_end", 32'(frame_err), 32'd0);
        send_line(W - 1, 1'b0, 1'b0);
        check("mid_full", 32'(dut.full_q), 32'd1);
        read_line("mid_a");
        read_line("mid_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
